// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - two-approach intersection sequencer, main street rests on green.
// Optional pedestrian path enabled by defining INTERSECTION_PED_EN.
module intersection_controller #(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_side,
  input  logic       ped_req,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALL_R1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    ALL_R2 = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             side_pend_q, side_pend_d;
  logic             expired, demand, enter_side;

  function automatic logic [CNT_W-1:0] load_val(input state_t s);
    case (s)
      MAIN_Y, SIDE_Y: load_val = YELLOW_LD;
      ALL_R1, ALL_R2: load_val = ALLRED_LD;
      default:        load_val = GREEN_LD;
    endcase
  endfunction

`ifdef INTERSECTION_PED_EN
  logic ped_pend_q, ped_pend_d, ped_served_q, ped_served_d;
  assign demand = side_pend_q | ped_pend_q | car_side | ped_req;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign demand     = side_pend_q | car_side;
`endif

  assign expired    = (timer_q == '0);
  assign enter_side = (state_d == SIDE_G) && (state_q != SIDE_G);

  always_comb begin
    state_d     = state_q;
    main_lights = LAMP_R;
    side_lights = LAMP_R;
    case (state_q)
      MAIN_G: begin
        main_lights = LAMP_G;
        if (expired && demand) state_d = MAIN_Y;
      end
      MAIN_Y: begin
        main_lights = LAMP_Y;
        if (expired) state_d = ALL_R1;
      end
      ALL_R1: if (expired) state_d = SIDE_G;
      SIDE_G: begin
        side_lights = LAMP_G;
        if (expired) state_d = SIDE_Y;
      end
      SIDE_Y: begin
        side_lights = LAMP_Y;
        if (expired) state_d = ALL_R2;
      end
      ALL_R2: if (expired) state_d = MAIN_G;
      // Unreachable codes fall back to all-red and recover through MAIN_G.
      default: state_d = MAIN_G;
    endcase
  end

  always_comb begin
    if (state_d != state_q) timer_d = load_val(state_d);
    else if (expired)       timer_d = '0;
    else                    timer_d = timer_q - 1'b1;
  end

  // Requests latch outside SIDE_G; entry to SIDE_G counts them all as served.
  always_comb begin
    side_pend_d = side_pend_q;
    if (enter_side)             side_pend_d = 1'b0;
    else if (state_q != SIDE_G) side_pend_d = side_pend_q | car_side;
  end

`ifdef INTERSECTION_PED_EN
  always_comb begin
    ped_pend_d   = ped_pend_q;
    ped_served_d = ped_served_q;
    if (enter_side) begin
      ped_pend_d   = 1'b0;
      ped_served_d = ped_pend_q | ped_req;
    end else if (state_q != SIDE_G) begin
      ped_pend_d = ped_pend_q | ped_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pend_q   <= 1'b0;
      ped_served_q <= 1'b0;
    end else begin
      ped_pend_q   <= ped_pend_d;
      ped_served_q <= ped_served_d;
    end
  end

  assign walk = (state_q == SIDE_G) && ped_served_q;
`else
  assign walk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MAIN_G;
      timer_q     <= GREEN_LD;
      side_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      side_pend_q <= side_pend_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// tb/tb_intersection_controller.sv - table vectors, corner sequences and random run vs a reference model.
module tb_intersection_controller;

  localparam int G = 8;
  localparam int Y = 2;
  localparam int A = 1;
`ifdef INTERSECTION_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_r = 1'b1;
  logic       car_r = 1'b0;
  logic       ped_r = 1'b0;
  logic [2:0] main_lights, side_lights, phase;
  logic       walk;

  int checks = 0;
  int errors = 0;

  intersection_controller #(
    .GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .ALLRED_CYCLES(A), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset_r), .car_side(car_r), .ped_req(ped_r),
    .main_lights(main_lights), .side_lights(side_lights), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  // Reference model: phase index plus cycles spent in it, and pending request booleans.
  int m_phase = 0;
  int m_cnt = 0;
  bit m_sp = 0, m_pp = 0, m_served = 0;

  function automatic int dur(input int p);
    case (p)
      1, 4:    dur = Y;
      2, 5:    dur = A;
      default: dur = G;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int p);
    case (p)
      0:       exp_main = 3'b001;
      1:       exp_main = 3'b010;
      default: exp_main = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int p);
    case (p)
      3:       exp_side = 3'b001;
      4:       exp_side = 3'b010;
      default: exp_side = 3'b100;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit car, input bit ped_raw);
    bit ped, done, dem;
    int nxt;
    ped = PED_EN && ped_raw;
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_sp = 0; m_pp = 0; m_served = 0;
    end else begin
      done = (m_cnt >= dur(m_phase) - 1);
      dem  = m_sp || m_pp || car || ped;
      nxt  = m_phase;
      if (done && (m_phase != 0 || dem)) nxt = (m_phase + 1) % 6;
      if (nxt == 3 && m_phase != 3) begin
        m_served = m_pp || ped;
        m_sp = 0; m_pp = 0;
      end else if (m_phase != 3) begin
        m_sp = m_sp || car;
        m_pp = m_pp || ped;
      end
      if (nxt != m_phase) m_cnt = 0;
      else if (m_cnt < 1000) m_cnt++;
      m_phase = nxt;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(reset_r, car_r, ped_r);
    #1;
    chk("model_phase", {5'd0, phase}, 8'(m_phase));
    chk("model_main", {5'd0, main_lights}, {5'd0, exp_main(m_phase)});
    chk("model_side", {5'd0, side_lights}, {5'd0, exp_side(m_phase)});
    chk("model_walk", {7'd0, walk}, {7'd0, (m_phase == 3) && m_served});
    chk("safety", {7'd0, (main_lights != 3'b100) && (side_lights != 3'b100)}, 8'd0);
  endtask

  task automatic do_reset();
    reset_r = 1'b1; car_r = 1'b0; ped_r = 1'b0;
    tick();
    reset_r = 1'b0;
  endtask

  task automatic wait_phase(input int target, input int budget);
    for (int i = 0; i < budget && phase != 3'(target); i++) tick();
    chk("wait_phase", {5'd0, phase}, 8'(target));
  endtask

  typedef struct {
    bit         rst;
    bit         car;
    bit         ped;
    logic [2:0] ph;
    bit         wk;
  } vec_t;

  vec_t vecs[44];
  int   seq[22];

  initial begin
    int k, cnt_walk, cnt_side, cnt_bad;

    k = 0;
    for (int p = 0; p < 6; p++)
      for (int j = 0; j < dur(p); j++) begin
        seq[k] = p; k++;
      end
    for (int i = 0; i < 44; i++)
      vecs[i] = '{rst: (i == 0), car: (i != 0), ped: 1'b0, ph: 3'(seq[i % 22]), wk: 1'b0};

    // Car held from reset: fixed 22-cycle phase pattern.
    for (int i = 0; i < 44; i++) begin
      reset_r = vecs[i].rst; car_r = vecs[i].car; ped_r = vecs[i].ped;
      tick();
      chk("tbl_phase", {5'd0, phase}, {5'd0, vecs[i].ph});
      chk("tbl_main", {5'd0, main_lights}, {5'd0, exp_main(int'(vecs[i].ph))});
      chk("tbl_side", {5'd0, side_lights}, {5'd0, exp_side(int'(vecs[i].ph))});
      chk("tbl_walk", {7'd0, walk}, {7'd0, vecs[i].wk});
    end

    // Idle after reset: rest on main green.
    do_reset();
    chk("rst_phase", {5'd0, phase}, 8'd0);
    chk("rst_main", {5'd0, main_lights}, 8'h01);
    chk("rst_side", {5'd0, side_lights}, 8'h04);
    chk("rst_walk", {7'd0, walk}, 8'd0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_phase", {5'd0, phase}, 8'd0);
    end

    // Single ped pulse in cycle 20, after main green has expired.
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    ped_r = 1'b1;
    tick();
    ped_r = 1'b0;
    chk("ped_c21_phase", {5'd0, phase}, PED_EN ? 8'd1 : 8'd0);
    cnt_walk = 0; cnt_bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (walk && phase == 3'd3) cnt_walk++;
      if (walk && phase != 3'd3) cnt_bad++;
    end
    chk("ped_walk_cycles", 8'(cnt_walk), PED_EN ? 8'd8 : 8'd0);
    chk("ped_walk_outside", 8'(cnt_bad), 8'd0);

    // Car pulse only inside SIDE_G must not cause a second service.
    do_reset();
    car_r = 1'b1; tick(); car_r = 1'b0;
    wait_phase(3, 40);
    car_r = 1'b1; tick(); car_r = 1'b0;
    wait_phase(0, 40);
    cnt_side = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (phase != 3'd0) cnt_side++;
    end
    chk("sideg_req_ignored", 8'(cnt_side), 8'd0);

    // Reset during SIDE_Y with a pending ped request discards it.
    do_reset();
    car_r = 1'b1; tick(); car_r = 1'b0;
    wait_phase(4, 60);
    ped_r = 1'b1; tick(); ped_r = 1'b0;
    chk("pre_rst_phase", {5'd0, phase}, 8'd4);
    reset_r = 1'b1; tick(); reset_r = 1'b0;
    chk("midrst_phase", {5'd0, phase}, 8'd0);
    chk("midrst_main", {5'd0, main_lights}, 8'h01);
    chk("midrst_side", {5'd0, side_lights}, 8'h04);
    chk("midrst_walk", {7'd0, walk}, 8'd0);
    cnt_side = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (phase != 3'd0) cnt_side++;
    end
    chk("midrst_no_service", 8'(cnt_side), 8'd0);

`ifndef INTERSECTION_PED_EN
    // Pedestrian path compiled out: toggling ped_req does nothing.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      ped_r = ~ped_r;
      tick();
      chk("noped_phase", {5'd0, phase}, 8'd0);
      chk("noped_walk", {7'd0, walk}, 8'd0);
    end
    ped_r = 1'b0;
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      car_r   = ($urandom_range(0, 15) == 0);
      ped_r   = ($urandom_range(0, 19) == 0);
      reset_r = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset_r = 1'b0; car_r = 1'b0; ped_r = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
